regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised multi-read, dual-write register file with same-cycle write-to-read bypass and a per-register busy scoreboard. Sits in the decode/writeback stage of the pipelined core: decode reads operands and marks destinations busy; two writeback paths (ALU, memory) retire results and clear busy bits. Supersedes the fixed 32x32, single-write, reset-less register file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and never becomes busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy flag of each read address after this cycle's writes
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  write port A (ALU writeback)
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write port B (memory writeback)
- sb_set_en / sb_set_addr  in  1 / ADDR_W  mark destination register busy (issue)
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits.
- Writes: on rising edge, each enabled port writes its register. Both ports same address: port B wins.
- Writes to address 0 discarded when ZERO_REG=1.
- Reads: combinational. Priority: ZERO_REG and address 0 gives 0, then same-cycle port B write to that address, then port A write, then stored value.
- Scoreboard: any enabled write clears the busy bit of its address. sb_set_en sets the bit of sb_set_addr. Set and clear on the same address in one cycle: set wins, because the new issue supersedes the retiring write. sb_set on address 0 ignored when ZERO_REG=1.
- rd_busy[i] = stored busy bit, masked off if a write to that address is enabled this cycle. The same-cycle set does not appear in rd_busy until the next cycle.
- busy_count: registered. Next value = popcount of next busy vector. It must always equal the number of set bits, and it saturates naturally at 2**ADDR_W.
- Setting a bit that is already busy or clearing a bit that is already idle is legal and has no effect beyond the bit value.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_count 0. rd_data reads 0 and rd_busy reads 0 combinationally during reset. Writes and sets are ignored while rst_n is low.
- Read latency: 0 cycles, including bypass. Write latency: visible from storage 1 cycle after the edge; bypass makes it visible in the same cycle.
- busy_count lags the busy vector by 0 cycles. Both update on the same edge.
- Reset asserted mid-operation discards all pending writes. Release is synchronous to the next rising edge; the first write can land on the first edge after release.

## Structure
- Shared package `regfile_pkg`: default DATA_W/ADDR_W constants and a `popcount` function, reused by the issue logic.
- One natural sub-module: `regfile_scoreboard` (busy vector, set/clear priority, busy_count). Storage and bypass muxing stay in the top level, with a generate loop over NUM_RD.

## Test plan
- Reset: drive rst_n low mid-run after writing R5=0xDEAD_BEEF -> rd_data for R5 is 0 immediately; busy_count=0; all rd_busy=0.
- Bypass: wa_en, addr 7, data 0x1234 and rd_addr0=7 in the same cycle -> rd_data0=0x1234 before the edge; R7 holds 0x1234 after the edge.
- Dual write collision: wa (R3, 0xAAAA) and wb (R3, 0x5555) together -> reads return 0x5555 in the same cycle and after the edge.
- Zero register (ZERO_REG=1): write R0=0xFFFF_FFFF and sb_set R0 -> R0 reads 0, rd_busy=0, busy_count unchanged.
- Scoreboard: set R4, set R9 -> busy_count=2. Next cycle, wb writes R4 while sb_set R4 -> R4 stays busy and busy_count=2. Then wa writes R9 -> rd_busy for R9 is 0 that cycle and busy_count=1.
- Params: NUM_RD=4, DATA_W=16, ADDR_W=3 -> 4 independent reads of 8 registers; a 16-bit write to R6 is read back on all ports.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the decode/writeback register file and the issue
// logic that sits next to it.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   POPCOUNT_MAX_W                  : widest vector popcount() accepts
//   rd_src_e                        : where a read port takes its data from
//   popcount()                      : number of set bits in a vector
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;

   // popcount() takes a fixed-width vector so that one function serves every
   // register-file size. Callers zero-extend their own vector into it, which
   // limits the scoreboard to ADDR_W <= 8 (256 registers).
   localparam int POPCOUNT_MAX_W = 256;

   // Read-port data source, in decreasing priority order.
   typedef enum logic [1:0] {
      SRC_ZERO  = 2'd0,   // hard-wired zero register
      SRC_WB    = 2'd1,   // same-cycle memory writeback
      SRC_WA    = 2'd2,   // same-cycle ALU writeback
      SRC_STORE = 2'd3    // value held in storage
   } rd_src_e;

   function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] vec);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
         cnt = cnt + int'(vec[i]);
      end
      return cnt;
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Per-register busy bits for the register file. Issue marks a destination
// busy, either writeback port retiring a result clears it. A set and a clear
// of the same register in one cycle leaves it busy: the new issue supersedes
// the older result that is retiring.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   clr_a_en / clr_a_addr    : clear request from write port A
//   clr_b_en / clr_b_addr    : clear request from write port B
//   set_en / set_addr        : set request from issue
//   busy_vec                 : current (registered) busy bits
//   busy_count               : registered popcount of busy_vec
// -----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_a_en,
   input  logic [ADDR_W-1:0]     clr_a_addr,
   input  logic                  clr_b_en,
   input  logic [ADDR_W-1:0]     clr_b_addr,
   input  logic                  set_en,
   input  logic [ADDR_W-1:0]     set_addr,
   output logic [2**ADDR_W-1:0]  busy_vec,
   output logic [ADDR_W:0]       busy_count
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [DEPTH-1:0]          busy_q;
   logic [DEPTH-1:0]          busy_d;
   logic [CNT_W-1:0]          busy_count_q;
   logic [CNT_W-1:0]          busy_count_d;
   logic                      set_ok;
   logic [POPCOUNT_MAX_W-1:0] busy_ext;

   always_comb begin
      // Register 0 never becomes busy when it is the hard-wired zero.
      set_ok = set_en && !(ZERO_REG && (set_addr == '0));

      busy_d = busy_q;
      if (clr_a_en) begin
         busy_d[clr_a_addr] = 1'b0;
      end
      if (clr_b_en) begin
         busy_d[clr_b_addr] = 1'b0;
      end
      // Applied last so that it overrides a clear of the same register.
      if (set_ok) begin
         busy_d[set_addr] = 1'b1;
      end

      // Count is derived from the next busy vector, so it can never drift
      // from the bits it summarises and tops out at DEPTH on its own.
      busy_ext                = '0;
      busy_ext[DEPTH-1:0]     = busy_d;
      busy_count_d            = CNT_W'(popcount(busy_ext));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busy_vec   = busy_q;
   assign busy_count = busy_count_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
//
// Multi-read, dual-write register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard. Decode reads operands and marks
// destinations busy; the ALU (port A) and memory (port B) writebacks retire
// results and clear busy bits.
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   rd_addr  [NUM_RD*ADDR_W]       : read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W]       : read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy  [NUM_RD]              : busy flag of each read address, with this
//                                    cycle's writes already retired
//   wa_en / wa_addr / wa_data      : write port A (ALU writeback)
//   wb_en / wb_addr / wb_data      : write port B (memory writeback), wins over A
//   sb_set_en / sb_set_addr        : mark a destination register busy
//   busy_count [ADDR_W+1]          : number of registers currently busy
//
// Reads are combinational with zero-latency bypass. While rst_n is low every
// read returns 0 and not busy, and no write or set is accepted.
// -----------------------------------------------------------------------------
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wa_en,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       sb_set_en,
   input  logic [ADDR_W-1:0]          sb_set_addr,
   output logic [ADDR_W:0]            busy_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wa_ok;
   logic              wb_ok;
   logic [DEPTH-1:0]  busy_vec;

   // Qualified write enables: a write to the hard-wired zero register is
   // dropped entirely, so it neither lands in storage nor bypasses.
   always_comb begin
      wa_ok = wa_en && !(ZERO_REG && (wa_addr == '0));
      wb_ok = wb_en && !(ZERO_REG && (wb_addr == '0));
   end

   // Next storage state; port B is applied after port A so it wins a collision.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         regs_d[r] = regs_q[r];
      end
      if (wa_ok) begin
         regs_d[wa_addr] = wa_data;
      end
      if (wb_ok) begin
         regs_d[wb_addr] = wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   // Busy tracking. Only qualified writes clear, so a dropped write to the
   // zero register has no side effect there either.
   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_a_en   (wa_ok),
      .clr_a_addr (wa_addr),
      .clr_b_en   (wb_ok),
      .clr_b_addr (wb_addr),
      .set_en     (sb_set_en),
      .set_addr   (sb_set_addr),
      .busy_vec   (busy_vec),
      .busy_count (busy_count)
   );

   // One bypass mux and busy lookup per read port.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic              hit_a;
         logic              hit_b;
         rd_src_e           src;
         logic [DATA_W-1:0] data;
         logic              busy;

         always_comb begin
            addr  = rd_addr[gi*ADDR_W +: ADDR_W];
            hit_a = wa_ok && (wa_addr == addr);
            hit_b = wb_ok && (wb_addr == addr);

            if (ZERO_REG && (addr == '0)) begin
               src = SRC_ZERO;
            end else if (hit_b) begin
               src = SRC_WB;
            end else if (hit_a) begin
               src = SRC_WA;
            end else begin
               src = SRC_STORE;
            end

            case (src)
               SRC_ZERO:  data = '0;
               SRC_WB:    data = wb_data;
               SRC_WA:    data = wa_data;
               SRC_STORE: data = regs_q[addr];
               default:   data = '0;
            endcase

            // A result retiring this cycle makes the register ready now; a
            // same-cycle issue only shows up once it is registered.
            busy = busy_vec[addr] && !hit_a && !hit_b;
         end

         // Bypass paths are combinational from the inputs, so gate them
         // explicitly to keep reads at 0 throughout reset.
         assign rd_data[gi*DATA_W +: DATA_W] = rst_n ? data : '0;
         assign rd_busy[gi]                  = rst_n && busy;
      end
   endgenerate

endmodule : regfile_bypass

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

   // ---------------- DUT 1: defaults (32-bit, 32 regs, 2 read ports) -------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wa_en, wb_en, sb_set_en;
   logic [4:0]  wa_addr, wb_addr, sb_set_addr;
   logic [31:0] wa_data, wb_data;
   logic [5:0]  busy_count;

   // ---------------- DUT 4: 16-bit, 8 regs, 4 read ports -------------------
   logic [11:0] rd_addr4;
   logic [63:0] rd_data4;
   logic [3:0]  rd_busy4;
   logic        wa4_en, wb4_en, sb4_set_en;
   logic [2:0]  wa4_addr, wb4_addr, sb4_set_addr;
   logic [15:0] wa4_data, wb4_data;
   logic [3:0]  busy_count4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_count(busy_count));

   regfile_bypass #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b1)) dut4 (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
      .wa_en(wa4_en), .wa_addr(wa4_addr), .wa_data(wa4_data),
      .wb_en(wb4_en), .wb_addr(wb4_addr), .wb_data(wb4_data),
      .sb_set_en(sb4_set_en), .sb_set_addr(sb4_set_addr), .busy_count(busy_count4));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- Behavioural model ------------------------------------
   // Storage keeps every write (even to R0); the "R0 reads 0" rule is applied
   // on the read side. A read shows the state the register will have after
   // this cycle's writes.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];
   logic [15:0] m4_mem [8];
   bit          m4_busy[8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_mem[k])  begin m_mem[k]  = '0; m_busy[k]  = 0; end
         foreach (m4_mem[k]) begin m4_mem[k] = '0; m4_busy[k] = 0; end
      end else begin
         if (wa_en) begin m_mem[wa_addr] = wa_data; m_busy[wa_addr] = 0; end
         if (wb_en) begin m_mem[wb_addr] = wb_data; m_busy[wb_addr] = 0; end
         if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1;
         if (wa4_en) begin m4_mem[wa4_addr] = wa4_data; m4_busy[wa4_addr] = 0; end
         if (wb4_en) begin m4_mem[wb4_addr] = wb4_data; m4_busy[wb4_addr] = 0; end
         if (sb4_set_en && sb4_set_addr != 0) m4_busy[sb4_set_addr] = 1;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (!rst_n || a == 0) return '0;
      v = m_mem[a];
      if (wa_en && wa_addr == a) v = wa_data;
      if (wb_en && wb_addr == a) v = wb_data;
      return v;
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      if (!rst_n) return 0;
      if ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) return 0;
      return m_busy[a];
   endfunction

   function automatic int exp_count();
      int c = 0;
      foreach (m_busy[k]) c += int'(m_busy[k]);
      return c;
   endfunction

   function automatic logic [15:0] exp_rd4(input logic [2:0] a);
      logic [15:0] v;
      if (!rst_n || a == 0) return '0;
      v = m4_mem[a];
      if (wa4_en && wa4_addr == a) v = wa4_data;
      if (wb4_en && wb4_addr == a) v = wb4_data;
      return v;
   endfunction

   function automatic bit exp_busy4(input logic [2:0] a);
      if (!rst_n) return 0;
      if ((wa4_en && wa4_addr == a) || (wb4_en && wb4_addr == a)) return 0;
      return m4_busy[a];
   endfunction

   function automatic int exp_count4();
      int c = 0;
      foreach (m4_busy[k]) c += int'(m4_busy[k]);
      return c;
   endfunction

   // ---------------- Compare process: every cycle, on the falling edge ----
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(exp_rd(rd_addr[i*5 +: 5])));
         chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(rd_addr[i*5 +: 5])));
      end
      chk("busy_count", 64'(busy_count), 64'(exp_count()));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("p4_rd_data%0d", i), 64'(rd_data4[i*16 +: 16]), 64'(exp_rd4(rd_addr4[i*3 +: 3])));
         chk($sformatf("p4_rd_busy%0d", i), 64'(rd_busy4[i]), 64'(exp_busy4(rd_addr4[i*3 +: 3])));
      end
      chk("p4_busy_count", 64'(busy_count4), 64'(exp_count4()));
   end

   // ---------------- Stimulus ---------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en = 0; wb_en = 0; sb_set_en = 0;
      wa4_en = 0; wb4_en = 0; sb4_set_en = 0;
   endtask

   function automatic logic [4:0] raddr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      rst_n = 0;
      rd_addr = '0; wa_addr = '0; wb_addr = '0; sb_set_addr = '0;
      wa_data = '0; wb_data = '0;
      rd_addr4 = '0; wa4_addr = '0; wb4_addr = '0; sb4_set_addr = '0;
      wa4_data = '0; wb4_data = '0;
      idle();
      step(); step();
      chk("reset_rd_data0", 64'(rd_data[31:0]), 64'h0);
      chk("reset_busy_count", 64'(busy_count), 64'h0);
      rst_n = 1;

      // Bypass: ALU write of R7 seen on port 0 before the edge, then stored.
      set_rd(5'd7, 5'd0);
      wa_en = 1; wa_addr = 5'd7; wa_data = 32'h0000_1234;
      #2 chk("bypass_same_cycle", 64'(rd_data[31:0]), 64'h1234);
      step(); idle();
      #2 chk("bypass_stored", 64'(rd_data[31:0]), 64'h1234);

      // Dual write to R3: port B wins.
      set_rd(5'd3, 5'd3);
      wa_en = 1; wa_addr = 5'd3; wa_data = 32'h0000_AAAA;
      wb_en = 1; wb_addr = 5'd3; wb_data = 32'h0000_5555;
      #2 chk("collision_same_cycle0", 64'(rd_data[31:0]), 64'h5555);
      chk("collision_same_cycle1", 64'(rd_data[63:32]), 64'h5555);
      step(); idle();
      #2 chk("collision_stored", 64'(rd_data[31:0]), 64'h5555);

      // Zero register ignores writes and sets.
      set_rd(5'd0, 5'd0);
      wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
      wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      sb_set_en = 1; sb_set_addr = 5'd0;
      #2 chk("r0_same_cycle", 64'(rd_data[31:0]), 64'h0);
      chk("r0_busy_same_cycle", 64'(rd_busy[0]), 64'h0);
      step(); idle();
      #2 chk("r0_stored", 64'(rd_data[31:0]), 64'h0);
      chk("r0_busy", 64'(rd_busy[0]), 64'h0);
      chk("r0_busy_count", 64'(busy_count), 64'h0);

      // Scoreboard sequence on R4 / R9.
      sb_set_en = 1; sb_set_addr = 5'd4; step();
      sb_set_addr = 5'd9; step(); idle();
      set_rd(5'd4, 5'd9);
      #2 chk("sb_count_two", 64'(busy_count), 64'h2);
      chk("sb_busy_both", 64'(rd_busy), 64'h3);
      wb_en = 1; wb_addr = 5'd4; wb_data = 32'h44;
      sb_set_en = 1; sb_set_addr = 5'd4;
      #2 chk("sb_retire_masks_r4", 64'(rd_busy[0]), 64'h0);
      step(); idle();
      #2 chk("sb_set_wins_count", 64'(busy_count), 64'h2);
      chk("sb_set_wins_busy", 64'(rd_busy[0]), 64'h1);
      wa_en = 1; wa_addr = 5'd9; wa_data = 32'h99;
      #2 chk("sb_r9_ready_same_cycle", 64'(rd_busy[1]), 64'h0);
      step(); idle();
      #2 chk("sb_count_one", 64'(busy_count), 64'h1);
      chk("sb_busy_after", 64'(rd_busy), 64'h1);

      // Asynchronous reset mid-run.
      wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
      sb_set_en = 1; sb_set_addr = 5'd5;
      step(); idle();
      set_rd(5'd5, 5'd4);
      #2 chk("r5_before_reset", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
      chk("count_before_reset", 64'(busy_count), 64'h2);
      rst_n = 0;
      #1 chk("r5_in_reset", 64'(rd_data[31:0]), 64'h0);
      chk("count_in_reset", 64'(busy_count), 64'h0);
      chk("busy_in_reset", 64'(rd_busy), 64'h0);
      step(); step();
      rst_n = 1;
      #2 chk("r5_after_reset", 64'(rd_data[31:0]), 64'h0);

      // 4-port, 16-bit instance: R6 read back on every port.
      rd_addr4 = {3'd6, 3'd6, 3'd6, 3'd6};
      wa4_en = 1; wa4_addr = 3'd6; wa4_data = 16'hBEEF;
      #2 for (int i = 0; i < 4; i++)
         chk($sformatf("p4_r6_bypass%0d", i), 64'(rd_data4[i*16 +: 16]), 64'hBEEF);
      step(); idle();
      #2 for (int i = 0; i < 4; i++)
         chk($sformatf("p4_r6_stored%0d", i), 64'(rd_data4[i*16 +: 16]), 64'hBEEF);

      // Randomized traffic on both instances with occasional reset pulses.
      for (int n = 0; n < 800; n++) begin
         step();
         if (!rst_n) rst_n = 1;
         wa_en = ($urandom_range(0, 2) != 0); wa_addr = raddr(); wa_data = $urandom;
         wb_en = ($urandom_range(0, 2) == 0);
         wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : raddr();
         wb_data = $urandom;
         sb_set_en = ($urandom_range(0, 1) == 0);
         sb_set_addr = ($urandom_range(0, 4) == 0) ? wa_addr : raddr();
         set_rd(($urandom_range(0, 2) == 0) ? wb_addr : raddr(), raddr());
         wa4_en = ($urandom_range(0, 1) == 0); wa4_addr = 3'($urandom); wa4_data = 16'($urandom);
         wb4_en = ($urandom_range(0, 2) == 0); wb4_addr = 3'($urandom); wb4_data = 16'($urandom);
         sb4_set_en = ($urandom_range(0, 1) == 0); sb4_set_addr = 3'($urandom);
         rd_addr4 = 12'($urandom);
         if (n % 250 == 249) #2 rst_n = 0;
      end
      step(); idle(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_bypass
